// File: rtl/hazard_stall_controller_pkg.sv
// Shared pipeline constants and FSM encoding for the hazard/stall controller.
package hazard_stall_controller_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MD_CNT_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard bundle between the pipeline datapath (master) and the stall controller (slave).
interface hazard_stall_controller_if
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic             memread_ex;
  logic [REG_W-1:0] rt_ex;
  logic [REG_W-1:0] rs_id;
  logic [REG_W-1:0] rt_id;
  logic             uses_rt_id;
  logic             md_start_id;
  logic             branch_taken_ex;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             md_go;
  logic             md_busy;
  logic             md_abort;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output memread_ex, rt_ex, rs_id, rt_id, uses_rt_id, md_start_id, branch_taken_ex,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, md_go, md_busy, md_abort,
           stall_cycles
  );

  modport slave (
    input  memread_ex, rt_ex, rs_id, rt_id, uses_rt_id, md_start_id, branch_taken_ex,
    output pc_write, ifid_write, idex_bubble, ifid_flush, md_go, md_busy, md_abort,
           stall_cycles
  );

endinterface

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Combinational load-use hazard compare; shared with the forwarding unit.
module load_use_detect
  import hazard_stall_controller_pkg::*;
(
  input  logic             memread_ex,
  input  logic [REG_W-1:0] rt_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             uses_rt_id,
  output logic             load_use
);

  // A load into $zero never produces a real dependency.
  always_comb begin
    load_use = memread_ex & (rt_ex != REG_ZERO) &
               ((rt_ex == rs_id) | (uses_rt_id & (rt_ex == rt_id)));
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline stall/flush controller: load-use bubbles, multi-cycle MD stalls,
// branch flush/abort and a saturating stall-cycle performance counter.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  hazard_stall_controller_if.slave   hz
);

  md_state_e             state, state_next;
  logic [MD_CNT_W-1:0]   md_cnt, md_cnt_next;
  logic [CNT_W-1:0]      stall_cnt;
  logic                  load_use;

  logic pc_write, ifid_write, idex_bubble, ifid_flush, md_go, md_busy, md_abort;

  load_use_detect u_load_use_detect (
    .memread_ex (hz.memread_ex),
    .rt_ex      (hz.rt_ex),
    .rs_id      (hz.rs_id),
    .rt_id      (hz.rt_id),
    .uses_rt_id (hz.uses_rt_id),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
    end
  end

  // Priority: taken branch > MD wait > load-use > MD start.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    md_go       = 1'b0;
    md_busy     = 1'b0;
    md_abort    = 1'b0;
    state_next  = state;
    md_cnt_next = md_cnt;

    if (hz.branch_taken_ex) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (state == MD_WAIT) begin
        md_abort    = 1'b1;
        md_cnt_next = '0;
        state_next  = RUN;
      end
    end else if (state == MD_WAIT) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      md_busy     = 1'b1;
      if (md_cnt == '0) begin
        state_next = RUN;
      end else begin
        md_cnt_next = md_cnt - MD_CNT_W'(1);
      end
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.md_start_id) begin
      // The go cycle is itself a stall, so the wait covers MD_LATENCY-1 cycles.
      md_go       = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      md_cnt_next = MD_CNT_W'(MD_LATENCY - 2);
      state_next  = MD_WAIT;
    end
  end

  // Stall counter saturates at all-ones; flush-only cycles keep pc_write high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.ifid_write   = ifid_write;
  assign hz.idex_bubble  = idex_bubble;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.md_go        = md_go;
  assign hz.md_busy      = md_busy;
  assign hz.md_abort     = md_abort;
  assign hz.stall_cycles = stall_cnt;

endmodule
